// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit: MIPS front end - PC, one-outstanding I-bus, 1-entry buffer    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package fetch_unit_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus_4;
      logic [31:0] instruction;
      logic [4:0]  rs;
      logic [4:0]  rt;
   } f_d_reg_t;
endpackage

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'hbfc0_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_judge,
   input  logic [31:0] branch_address,
   input  logic        jump_judge,
   input  logic [31:0] jump_address,
   output logic        ireq_valid,
   output logic [31:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   output f_d_reg_t    f_d_reg,
   output logic        f_d_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_addr;
   logic        r_buf_valid;
   logic [31:0] r_buf_pc;
   logic [31:0] r_buf_instr;

   logic        w_redirect;
   logic [31:0] w_sel_addr;
   logic [31:0] w_target;
   logic        w_drain;
   logic        w_free;
   logic        w_req_valid;
   logic [31:0] w_req_addr;

   always_comb begin
      w_redirect = branch_judge | jump_judge;
      w_sel_addr = branch_judge ? branch_address : jump_address;
      w_target   = {w_sel_addr[31:2], 2'b00};
      w_drain    = r_buf_valid & ~stall;
      w_free     = ~r_buf_valid | w_drain | w_redirect;
      w_req_valid = 1'b0;
      w_req_addr  = r_req_addr;
      case (r_state)
         S_IDLE: begin
            w_req_valid = w_free;
            w_req_addr  = w_redirect ? w_target : r_pc;
         end
         S_WAIT, S_DROP: begin
            w_req_valid = 1'b1;
            w_req_addr  = r_req_addr;
         end
         default: begin
            w_req_valid = 1'b0;
            w_req_addr  = r_req_addr;
         end
      endcase
   end

   assign ireq_valid = w_req_valid & ~reset;
   assign ireq_addr  = w_req_addr;
   // A buffered instruction on the wrong path is hidden from decode at once.
   assign f_d_valid  = r_buf_valid & ~w_redirect & ~reset;
   assign f_d_reg    = '{pc:          r_buf_pc,
                         pc_plus_4:   r_buf_pc + 32'd4,
                         instruction: r_buf_instr,
                         rs:          r_buf_instr[25:21],
                         rt:          r_buf_instr[20:16]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pc        <= PC_RESET;
         r_req_addr  <= 32'd0;
         r_buf_valid <= 1'b0;
         r_buf_pc    <= 32'd0;
         r_buf_instr <= 32'd0;
      end else begin
         if (w_redirect || w_drain)
            r_buf_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_free) begin
                  if (iresp_data_ok) begin
                     r_buf_valid <= 1'b1;
                     r_buf_pc    <= w_req_addr;
                     r_buf_instr <= iresp_data;
                     r_pc        <= w_req_addr + 32'd4;
                  end else begin
                     r_req_addr <= w_req_addr;
                     r_pc       <= w_req_addr;
                     r_state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Buffer is guaranteed empty here: issue only happened when free.
               if (iresp_data_ok) begin
                  if (!w_redirect) begin
                     r_buf_valid <= 1'b1;
                     r_buf_pc    <= r_req_addr;
                     r_buf_instr <= iresp_data;
                     r_pc        <= r_req_addr + 32'd4;
                  end else begin
                     r_pc <= w_target;
                  end
                  r_state <= S_IDLE;
               end else if (w_redirect) begin
                  r_pc    <= w_target;
                  r_state <= S_DROP;
               end
            end
            S_DROP: begin
               if (w_redirect)
                  r_pc <= w_target;
               if (iresp_data_ok)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit: randomized + directed bench with stream-level model       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] PC_RESET = 32'hbfc0_0000;
   localparam logic [31:0] XORK     = 32'h5a5a_5a5a;

   logic        clk = 1'b0;
   logic        reset, stall, branch_judge, jump_judge, iresp_data_ok;
   logic [31:0] branch_address, jump_address, iresp_data, ireq_addr;
   logic        ireq_valid, f_d_valid;
   f_d_reg_t    f_d_reg;

   always #5 clk = ~clk;

   fetch_unit #(.PC_RESET(PC_RESET)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_judge(branch_judge), .branch_address(branch_address),
      .jump_judge(jump_judge), .jump_address(jump_address),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .f_d_reg(f_d_reg), .f_d_valid(f_d_valid)
   );

   int n_pass = 0, n_total = 0;

   // memory model
   int          lat_mode;
   logic        force_ok;
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_cnt;

   // stream model: the pc the next presented instruction must carry
   logic [31:0] exp_pc;
   int          idle_cnt;
   logic        prev_hold;
   logic [31:0] prev_pc;

   logic        s_ireq_valid, s_fd_valid;
   logic [31:0] s_ireq_addr, s_fd_pc;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: bound expired without the expected event", name);
   endtask

   task automatic cycle();
      logic        redir;
      logic [31:0] tgt, ei;
      @(negedge clk);
      #1;
      if (reset) begin
         mem_busy      = 1'b0;
         iresp_data_ok = force_ok;
         iresp_data    = $urandom;
      end else if (ireq_valid) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_addr = ireq_addr;
            mem_cnt  = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
         end else begin
            check_eq("ireq_addr_stable", ireq_addr, mem_addr);
         end
         check_eq("ireq_addr_align", {30'd0, ireq_addr[1:0]}, 32'd0);
         iresp_data_ok = (mem_cnt == 0);
         iresp_data    = iresp_data_ok ? (mem_addr ^ XORK) : $urandom;
      end else begin
         if (mem_busy) begin
            fail_now("ireq_withdrawn_before_data_ok");
            mem_busy = 1'b0;
         end
         iresp_data_ok = 1'b0;
         iresp_data    = $urandom;
      end
      #1;
      s_ireq_valid = ireq_valid;
      s_ireq_addr  = ireq_addr;
      s_fd_valid   = f_d_valid;
      s_fd_pc      = f_d_reg.pc;
      if (reset) begin
         check_eq("reset_ireq_valid", 32'(ireq_valid), 32'd0);
         check_eq("reset_fd_valid", 32'(f_d_valid), 32'd0);
         exp_pc    = PC_RESET;
         prev_hold = 1'b0;
         idle_cnt  = 0;
      end else begin
         redir = branch_judge | jump_judge;
         tgt   = branch_judge ? branch_address : jump_address;
         tgt[1:0] = 2'b00;
         if (prev_hold && !redir) begin
            check_eq("stall_hold_valid", 32'(f_d_valid), 32'd1);
            check_eq("stall_hold_pc", f_d_reg.pc, prev_pc);
         end
         if (f_d_valid && stall)
            check_eq("no_req_while_full", 32'(ireq_valid), 32'd0);
         if (redir) begin
            check_eq("fd_valid_on_redirect", 32'(f_d_valid), 32'd0);
            exp_pc   = tgt;
            idle_cnt = 0;
         end else if (f_d_valid) begin
            ei = exp_pc ^ XORK;
            check_eq("fd_pc", f_d_reg.pc, exp_pc);
            check_eq("fd_pc_plus_4", f_d_reg.pc_plus_4, exp_pc + 32'd4);
            check_eq("fd_instr", f_d_reg.instruction, ei);
            check_eq("fd_rs_rt", {22'd0, f_d_reg.rs, f_d_reg.rt}, {22'd0, ei[25:21], ei[20:16]});
            if (!stall) begin
               exp_pc   = exp_pc + 32'd4;
               idle_cnt = 0;
            end
         end else if (!stall) begin
            idle_cnt++;
            if (idle_cnt > 16) begin
               fail_now("fetch_progress");
               idle_cnt = 0;
            end
         end
         prev_hold = f_d_valid & stall & ~redir;
         prev_pc   = f_d_reg.pc;
      end
      @(posedge clk);
      #1;
      if (!reset && mem_busy) begin
         if (iresp_data_ok) mem_busy = 1'b0;
         else               mem_cnt--;
      end
   endtask

   task automatic do_reset(input int lat);
      lat_mode = lat;
      reset = 1'b1; force_ok = 1'b0; stall = 1'b0;
      branch_judge = 1'b0; jump_judge = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   task automatic run_until_valid(input string name);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!s_fd_valid && n < 20);
      if (!s_fd_valid) fail_now(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; stall = 1'b0; force_ok = 1'b0;
      branch_judge = 1'b0; jump_judge = 1'b0;
      branch_address = 32'd0; jump_address = 32'd0;
      iresp_data_ok = 1'b0; iresp_data = 32'd0;
      mem_busy = 1'b0; mem_addr = 32'd0; mem_cnt = 0; lat_mode = 0;
      exp_pc = PC_RESET; idle_cnt = 0; prev_hold = 1'b0; prev_pc = 32'd0;

      // zero-wait memory, back-to-back delivery
      do_reset(0);
      cycle();
      check_eq("p1_first_req_valid", 32'(s_ireq_valid), 32'd1);
      check_eq("p1_first_req_addr", s_ireq_addr, 32'hbfc0_0000);
      check_eq("p1_first_fd_valid", 32'(s_fd_valid), 32'd0);
      cycle(); check_eq("p1_pc0", s_fd_pc, 32'hbfc0_0000);
      cycle(); check_eq("p1_pc1", s_fd_pc, 32'hbfc0_0004);
      cycle(); check_eq("p1_pc2", s_fd_pc, 32'hbfc0_0008);

      // 3-cycle memory with decode stalled
      do_reset(3);
      stall = 1'b1;
      run_until_valid("p2_first_valid");
      check_eq("p2_first_pc", s_fd_pc, 32'hbfc0_0000);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check_eq("p2_stall_pc", s_fd_pc, 32'hbfc0_0000);
         check_eq("p2_stall_no_req", 32'(s_ireq_valid), 32'd0);
      end
      stall = 1'b0;
      cycle();
      check_eq("p2_release_pc", s_fd_pc, 32'hbfc0_0000);
      run_until_valid("p2_resume_valid");
      check_eq("p2_resume_pc", s_fd_pc, 32'hbfc0_0004);

      // branch while waiting on 0xbfc00008
      do_reset(3);
      n = 0;
      do begin cycle(); n++; end
      while (!(s_ireq_valid && s_ireq_addr == 32'hbfc0_0008) && n < 40);
      if (n >= 40) fail_now("p3_reach_wait");
      branch_judge = 1'b1; branch_address = 32'hbfc0_0100;
      cycle();
      check_eq("p3_fd_valid_redirect", 32'(s_fd_valid), 32'd0);
      check_eq("p3_addr_held", s_ireq_addr, 32'hbfc0_0008);
      branch_judge = 1'b0;
      n = 0;
      do begin cycle(); n++; end
      while (s_ireq_addr == 32'hbfc0_0008 && n < 10);
      check_eq("p3_drop_hold_cycles", n - 1, 32'd2);
      check_eq("p3_next_req", s_ireq_addr, 32'hbfc0_0100);
      run_until_valid("p3_target_valid");
      check_eq("p3_target_pc", s_fd_pc, 32'hbfc0_0100);

      // jump with 0-wait response in the redirect cycle, misaligned target
      do_reset(0);
      cycle(); cycle(); cycle();
      jump_judge = 1'b1; jump_address = 32'hbfc0_0203;
      cycle();
      check_eq("p4_req_addr", s_ireq_addr, 32'hbfc0_0200);
      jump_judge = 1'b0;
      cycle(); check_eq("p4_pc0", s_fd_pc, 32'hbfc0_0200);
      cycle(); check_eq("p4_pc1", s_fd_pc, 32'hbfc0_0204);

      // branch has priority over jump
      do_reset(0);
      cycle(); cycle();
      branch_judge = 1'b1; branch_address = 32'h0000_0100;
      jump_judge   = 1'b1; jump_address   = 32'h0000_0200;
      cycle();
      check_eq("p5_req_addr", s_ireq_addr, 32'h0000_0100);
      branch_judge = 1'b0; jump_judge = 1'b0;
      cycle(); check_eq("p5_pc0", s_fd_pc, 32'h0000_0100);
      cycle(); check_eq("p5_pc1", s_fd_pc, 32'h0000_0104);

      // reset in WAIT with a response landing during reset
      do_reset(3);
      cycle(); cycle();
      reset = 1'b1; force_ok = 1'b1;
      cycle(); cycle();
      reset = 1'b0; force_ok = 1'b0;
      cycle();
      check_eq("p6_fd_valid_after_reset", 32'(s_fd_valid), 32'd0);
      check_eq("p6_restart_addr", s_ireq_addr, PC_RESET);
      run_until_valid("p6_restart_valid");
      check_eq("p6_restart_pc", s_fd_pc, PC_RESET);

      // randomized traffic, latencies 0..3, redirects, stalls, wrap, resets
      do_reset(-1);
      for (int c = 0; c < 3000; c++) begin
         int r;
         stall = ($urandom_range(3, 0) == 0);
         r = int'($urandom_range(15, 0));
         branch_judge = (r == 0 || r == 2);
         jump_judge   = (r == 1 || r == 2);
         branch_address = ($urandom_range(7, 0) == 0) ? 32'hffff_fff0 + 32'($urandom_range(15, 0))
                                                      : 32'hbfc0_0000 + 32'($urandom_range(4095, 0));
         jump_address   = ($urandom_range(7, 0) == 0) ? 32'hffff_fff0 + 32'($urandom_range(15, 0))
                                                      : 32'hbfc0_0000 + 32'($urandom_range(4095, 0));
         reset    = ($urandom_range(399, 0) == 0);
         force_ok = 1'($urandom_range(1, 0));
         cycle();
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
